disjoint_switch: RTL and testbench
==================================

# disjoint_switch

Programmable disjoint-topology switch box for the FPGA routing fabric, sitting at the crossing of horizontal and vertical routing channels. Each of its W tracks is bidirectional and appears on all four sides: left, right, top and bottom. Track k on one side can connect only to track k on the other sides. The connection pattern comes from an 8·W-bit configuration shift register, which is daisy-chained with neighbouring blocks through prog_in/prog_out.

## Interface
- W, default 1: number of tracks per side. The configuration length is N = 8·W bits.

- prog_clk  input  1  programming clock; the block's only clock.
- prog_rst  input  1  synchronous, active-high reset of the configuration register.
- prog_en  input  1  shift enable for the configuration chain.
- prog_in  input  1  serial configuration data in.
- prog_out  output  1  serial configuration data out; drives the next block in the chain.
- l  inout  W  left-side tracks.
- r  inout  W  right-side tracks.
- t  inout  W  top-side tracks.
- b  inout  W  bottom-side tracks.

## Operation
- **Configuration register:** cfg[N-1:0].
  - On rising prog_clk with prog_rst=1: cfg <= 0.
  - Otherwise, if prog_en=1: cfg <= {prog_in, cfg[N-1:1]}, a right shift.
  - Otherwise cfg holds.
  - prog_out = cfg[0], combinational from the register.
  - Result of the shift order: the first bit shifted in ends at cfg[0] after N shifts.
- **Field layout:** 4·W two-bit select fields.
  - Field index f = s·W + k, where side s is l=0, r=1, t=2, b=3 and k is the track number.
  - Field f occupies cfg[2f+1:2f].
- **Select codes:** each field sets what drives pin k on side s.
  - l: 00 = hi-Z, 01 = r[k], 10 = t[k], 11 = b[k].
  - r: 00 = hi-Z, 01 = l[k], 10 = b[k], 11 = t[k].
  - t: 00 = hi-Z, 01 = b[k], 10 = r[k], 11 = l[k].
  - b: 00 = hi-Z, 01 = t[k], 10 = l[k], 11 = r[k].
- **Sources:** the source is the resolved net value on the selected pin, so the output buffer is a tri-state driver fed by a 3:1 mux.
- **Driver gating:** all pin drivers are forced to hi-Z while prog_en=1. This prevents contention from partially shifted configurations. Drivers re-enable combinationally once prog_en returns to 0.
- **Illegal configurations:**
  - Mutual selection, e.g. l[k] selecting r[k] while r[k] selects l[k], is a combinational loop.
  - Any cyclic selection among sides is likewise illegal.
  - The block does not detect illegal configurations. Pin values are undefined (X is acceptable) under them.
- **Reset state:** after reset all fields are 00 and all 4·W pins are hi-Z.

## Timing
- Configuration changes only on the rising edge of prog_clk. Reset takes priority over shift.
- prog_out is valid immediately after each rising edge. It is stable while prog_clk is low, and the upstream/downstream chain samples it on the next rising edge.
- Routing path from source pin to destination pin is purely combinational: zero cycles, no clock involvement.
- Programming a full block takes exactly N rising edges with prog_en=1. During those N edges the prior contents shift out on prog_out, bit 0 first.
- If prog_rst asserts mid-programming, cfg clears on that edge and the partial shift is discarded. prog_out becomes 0.
- If prog_en drops mid-sequence, the partially shifted cfg is retained and applied to the drivers. Re-programming requires a fresh N-edge sequence.

## Test plan
- **Reset:** assert prog_rst for one prog_clk edge.
  - prog_out=0.
  - All of l, r, t, b read Z with no external drive.
- **Shift-through (W=3, N=24):** shift 24'h0, then pattern P=24'hA5C3F0 with prog_en=1.
  - During the second pass, before shift i, prog_out equals previous contents bit i (all 0).
  - A third pass with 24'h0 returns P[i] on prog_out before shift i.
- **Straight routes (W=3):** program 24'b000000010101010101000000, then drop prog_en.
  - Drive b=3'b111 → t reads 3'b111.
  - Then drive l=3'b111 → r reads 3'b111.
  - l and b are not driven by the block.
- **Turn routes:** program l field k=0 to 10 (t) and b field k=2 to 11 (r), all other fields 00.
  - Drive t[0]=1, r[2]=0 → l[0]=1, b[2]=0.
  - All other pins read Z.
- **Gating:** with a valid configuration loaded, raise prog_en.
  - All destination pins go Z immediately.
  - They restore when prog_en falls, with no shift edge in between.
- **Reset mid-program:** shift 10 bits, pulse prog_rst.
  - cfg reads all zero when shifted out on the following 24 edges.
  - All pins read Z.

Source files
------------

// File: rtl/disjoint_switch.sv
// Disjoint-topology routing switch box: W bidirectional tracks on four sides.
// The select fields come from a serial configuration chain.
module disjoint_switch #(
    parameter int W = 1
) (
    input  logic         prog_clk,
    input  logic         prog_rst,
    input  logic         prog_en,
    input  logic         prog_in,
    output logic         prog_out,
    inout  wire  [W-1:0] l,
    inout  wire  [W-1:0] r,
    inout  wire  [W-1:0] t,
    inout  wire  [W-1:0] b
);

    localparam int N = 8 * W;

    // Side ordinals used to locate a field: field f = side * W + track.
    typedef enum int {
        SIDE_L = 0,
        SIDE_R = 1,
        SIDE_T = 2,
        SIDE_B = 3
    } side_e;

    logic [N-1:0] r_cfg;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge prog_clk) begin
        if (prog_rst) begin
            r_cfg <= '0;
        end else if (prog_en) begin
            r_cfg <= {prog_in, r_cfg[N-1:1]};
        end
    end

    assign prog_out = r_cfg[0];

    // Code 00 never reaches this mux because the driver is already off.
    function automatic logic pick3(
        input logic [1:0] sel,
        input logic       src_a,
        input logic       src_b,
        input logic       src_c
    );
        logic res;
        case (sel)
            2'b01:   res = src_a;
            2'b10:   res = src_b;
            default: res = src_c;
        endcase
        return res;
    endfunction

    for (genvar k = 0; k < W; k++) begin : g_track
        logic [1:0] w_sel_l;
        logic [1:0] w_sel_r;
        logic [1:0] w_sel_t;
        logic [1:0] w_sel_b;
        logic       w_src_l;
        logic       w_src_r;
        logic       w_src_t;
        logic       w_src_b;
        logic       w_oe_l;
        logic       w_oe_r;
        logic       w_oe_t;
        logic       w_oe_b;

        assign w_sel_l = r_cfg[2 * (int'(SIDE_L) * W + k) +: 2];
        assign w_sel_r = r_cfg[2 * (int'(SIDE_R) * W + k) +: 2];
        assign w_sel_t = r_cfg[2 * (int'(SIDE_T) * W + k) +: 2];
        assign w_sel_b = r_cfg[2 * (int'(SIDE_B) * W + k) +: 2];

        // Sources are the resolved pin values, so the routing path is purely combinational.
        assign w_src_l = pick3(w_sel_l, r[k], t[k], b[k]);
        assign w_src_r = pick3(w_sel_r, l[k], b[k], t[k]);
        assign w_src_t = pick3(w_sel_t, b[k], r[k], l[k]);
        assign w_src_b = pick3(w_sel_b, t[k], l[k], r[k]);

        // Drivers stay off while shifting so half-loaded patterns cannot fight.
        assign w_oe_l = !prog_en && (w_sel_l != 2'b00);
        assign w_oe_r = !prog_en && (w_sel_r != 2'b00);
        assign w_oe_t = !prog_en && (w_sel_t != 2'b00);
        assign w_oe_b = !prog_en && (w_sel_b != 2'b00);

        assign l[k] = w_oe_l ? w_src_l : 1'bz;
        assign r[k] = w_oe_r ? w_src_r : 1'bz;
        assign t[k] = w_oe_t ? w_src_t : 1'bz;
        assign b[k] = w_oe_b ? w_src_b : 1'bz;
    end

endmodule

// File: tb/tb_disjoint_switch.sv
// Bench for disjoint_switch: two identically programmed copies, one on pulled-up
// nets and one on pulled-down nets, so an undriven pin shows up as a disagreement.
module tb_disjoint_switch;

    localparam int W = 3;
    localparam int N = 8 * W;

    localparam logic [N-1:0] PAT_P        = 24'hA5C3F0;
    localparam logic [N-1:0] CFG_STRAIGHT = 24'b000000010101010101000000;
    localparam logic [N-1:0] CFG_TURN     = 24'hC00002;

    logic prog_clk;
    logic prog_rst;
    logic prog_en;
    logic prog_in;
    logic out_pu;
    logic out_pd;

    tri1 [W-1:0] l_pu, r_pu, t_pu, b_pu;
    tri0 [W-1:0] l_pd, r_pd, t_pd, b_pd;

    logic [W-1:0] l_oe, l_dv, r_oe, r_dv, t_oe, t_dv, b_oe, b_dv;

    int total;
    int bad;

    for (genvar k = 0; k < W; k++) begin : g_drv
        assign l_pu[k] = l_oe[k] ? l_dv[k] : 1'bz;
        assign r_pu[k] = r_oe[k] ? r_dv[k] : 1'bz;
        assign t_pu[k] = t_oe[k] ? t_dv[k] : 1'bz;
        assign b_pu[k] = b_oe[k] ? b_dv[k] : 1'bz;
        assign l_pd[k] = l_oe[k] ? l_dv[k] : 1'bz;
        assign r_pd[k] = r_oe[k] ? r_dv[k] : 1'bz;
        assign t_pd[k] = t_oe[k] ? t_dv[k] : 1'bz;
        assign b_pd[k] = b_oe[k] ? b_dv[k] : 1'bz;
    end

    disjoint_switch #(.W(W)) u_dut_pu (
        .prog_clk (prog_clk),
        .prog_rst (prog_rst),
        .prog_en  (prog_en),
        .prog_in  (prog_in),
        .prog_out (out_pu),
        .l        (l_pu),
        .r        (r_pu),
        .t        (t_pu),
        .b        (b_pu)
    );

    disjoint_switch #(.W(W)) u_dut_pd (
        .prog_clk (prog_clk),
        .prog_rst (prog_rst),
        .prog_en  (prog_en),
        .prog_in  (prog_in),
        .prog_out (out_pd),
        .l        (l_pd),
        .r        (r_pd),
        .t        (t_pd),
        .b        (b_pd)
    );

    initial begin
        prog_clk = 1'b0;
        forever #5 prog_clk = ~prog_clk;
    end

    // Per side: {driven mask, driven value}; a pin is driven when both copies agree.
    function automatic logic [5:0] side_key(input logic [W-1:0] pu, input logic [W-1:0] pd);
        logic [W-1:0] drv;
        drv = ~(pu ^ pd);
        return {drv, pu & drv};
    endfunction

    function automatic logic [23:0] pins();
        return {side_key(l_pu, l_pd), side_key(r_pu, r_pd),
                side_key(t_pu, t_pd), side_key(b_pu, b_pd)};
    endfunction

    task automatic release_pins();
        l_oe = '0; l_dv = '0; r_oe = '0; r_dv = '0;
        t_oe = '0; t_dv = '0; b_oe = '0; b_dv = '0;
    endtask

    // Shift one full pass, checking the previous contents leave bit 0 first.
    task automatic shift_pass(input logic [N-1:0] data, input logic [N-1:0] prior, input string tag);
        for (int i = 0; i < N; i++) begin
            @(negedge prog_clk);
            #1;
            total++;
            if ({out_pu, out_pd} !== {2{prior[i]}}) begin
                bad++;
                $display("FAIL %s bit %0d: prog_out=%b/%b expected %b", tag, i, out_pu, out_pd, prior[i]);
            end
            prog_in = data[i];
            prog_en = 1'b1;
        end
        @(negedge prog_clk);
        #1;
        prog_en = 1'b0;
        prog_in = 1'b0;
    endtask

    task automatic test_reset();
        prog_rst = 1'b1;
        @(negedge prog_clk);
        #1;
        prog_rst = 1'b0;
        total++;
        if ({out_pu, out_pd} !== 2'b00) begin
            bad++;
            $display("FAIL reset_prog_out: got %b/%b expected 0", out_pu, out_pd);
        end
        total++;
        if (pins() !== 24'h000000) begin
            bad++;
            $display("FAIL reset_pins: got %h expected 000000", pins());
        end
    endtask

    task automatic test_shift_through();
        shift_pass('0, '0, "flush");
        shift_pass(PAT_P, '0, "load_p");
        shift_pass('0, PAT_P, "unload_p");
    endtask

    task automatic test_straight();
        shift_pass(CFG_STRAIGHT, '0, "load_straight");
        b_oe = 3'b111; b_dv = 3'b111;
        #1;
        total++;
        if (side_key(t_pu, t_pd) !== 6'b111111) begin
            bad++;
            $display("FAIL straight_b_to_t: got %b expected 111111", side_key(t_pu, t_pd));
        end
        l_oe = 3'b111; l_dv = 3'b111;
        #1;
        total++;
        if (pins() !== 24'hFFFFFF) begin
            bad++;
            $display("FAIL straight_l_to_r: got %h expected ffffff", pins());
        end
        l_dv = 3'b010; b_dv = 3'b101;
        #1;
        total++;
        if (pins() !== 24'hEBAF7D) begin
            bad++;
            $display("FAIL straight_mixed: got %h expected ebaf7d", pins());
        end
        release_pins();
        #1;
        total++;
        if (pins() !== 24'h000000) begin
            bad++;
            $display("FAIL straight_released: got %h expected 000000", pins());
        end
    endtask

    task automatic test_turn();
        shift_pass(CFG_TURN, CFG_STRAIGHT, "load_turn");
        t_oe = 3'b001; t_dv = 3'b001;
        r_oe = 3'b100; r_dv = 3'b000;
        #1;
        total++;
        if (pins() !== 24'h260260) begin
            bad++;
            $display("FAIL turn_t1_r0: got %h expected 260260", pins());
        end
        t_dv = 3'b000; r_dv = 3'b100;
        #1;
        total++;
        if (pins() !== 24'h224224) begin
            bad++;
            $display("FAIL turn_t0_r1: got %h expected 224224", pins());
        end
    endtask

    task automatic test_gating();
        @(negedge prog_clk);
        t_oe = 3'b001; t_dv = 3'b001;
        r_oe = 3'b100; r_dv = 3'b000;
        #1;
        prog_en = 1'b1;
        #1;
        total++;
        if (pins() !== 24'h020240) begin
            bad++;
            $display("FAIL gating_off: got %h expected 020240", pins());
        end
        prog_en = 1'b0;
        #1;
        total++;
        if (pins() !== 24'h260260) begin
            bad++;
            $display("FAIL gating_restore: got %h expected 260260", pins());
        end
    endtask

    task automatic test_reset_mid_program();
        release_pins();
        for (int i = 0; i < 10; i++) begin
            @(negedge prog_clk);
            #1;
            total++;
            if ({out_pu, out_pd} !== {2{CFG_TURN[i]}}) begin
                bad++;
                $display("FAIL partial_shift bit %0d: prog_out=%b/%b expected %b", i, out_pu, out_pd, CFG_TURN[i]);
            end
            prog_in = 1'b1;
            prog_en = 1'b1;
        end
        @(negedge prog_clk);
        #1;
        prog_rst = 1'b1;
        @(negedge prog_clk);
        #1;
        prog_rst = 1'b0;
        prog_en = 1'b0;
        prog_in = 1'b0;
        total++;
        if ({out_pu, out_pd} !== 2'b00) begin
            bad++;
            $display("FAIL mid_reset_prog_out: got %b/%b expected 0", out_pu, out_pd);
        end
        total++;
        if (pins() !== 24'h000000) begin
            bad++;
            $display("FAIL mid_reset_pins: got %h expected 000000", pins());
        end
        shift_pass('0, '0, "after_mid_reset");
    endtask

    initial begin
        total = 0;
        bad = 0;
        prog_rst = 1'b1;
        prog_en = 1'b0;
        prog_in = 1'b0;
        release_pins();
        @(negedge prog_clk);

        test_reset();
        test_shift_through();
        test_straight();
        test_turn();
        test_gating();
        test_reset_mid_program();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
